// File: rtl/preset_midi_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : preset_midi_tx                                             |
// | Description : Two-slot preset table with a serial MIDI Program Change    |
// |               transmitter (8N1). A save event stores learn_program into  |
// |               the selected slot. A recall event sends {C,ch} then        |
// |               {0,prog}. A recall that arrives while busy is held in a     |
// |               single pending register, and the latest recall wins.       |
// | Ports       : clk, rst (async, active high)                              |
// |               btn_index[1:0], save_mode, learn_program[6:0] : events     |
// |               midi_out : serial line, idle high (registered)             |
// |               busy     : frame on the line                               |
// |               tx_done  : one-cycle pulse after the final stop bit        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module preset_midi_tx #(
    parameter int         CLK_DIV    = 864,
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter logic [6:0] PROG1_INIT = 7'd0,
    parameter logic [6:0] PROG2_INIT = 7'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_index,
    input  logic       save_mode,
    input  logic [6:0] learn_program,
    output logic       midi_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int            BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0] c_baud_last = BW'(CLK_DIV - 1);
    localparam logic [7:0]    c_status    = {4'hC, CHANNEL};

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]    r_state, w_state_n;
    logic [BW-1:0] r_baud, w_baud_n;
    logic [2:0]    r_bit, w_bit_n;
    logic          r_sel, w_sel_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [6:0]    r_prog_lat, w_prog_lat_n;
    logic          r_midi, w_midi_n;
    logic          r_busy, w_busy_n;
    logic          r_done, w_done_n;
    logic          r_pend, w_pend_n;
    logic          r_pend_slot, w_pend_slot_n;  // 0 = slot 1, 1 = slot 2
    logic [6:0]    r_prog1, r_prog2;

    logic w_valid_slot, w_save, w_recall, w_wrap;

    assign w_valid_slot = (btn_index == 2'd1) || (btn_index == 2'd2);
    assign w_save       = w_valid_slot && save_mode;
    assign w_recall     = w_valid_slot && !save_mode;
    assign w_wrap       = (r_baud == c_baud_last);

    // Slot table; saves are honoured at any time, even mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prog1 <= PROG1_INIT;
            r_prog2 <= PROG2_INIT;
        end else if (w_save) begin
            if (btn_index == 2'd1) r_prog1 <= learn_program;
            else                   r_prog2 <= learn_program;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_baud_n      = r_baud;
        w_bit_n       = r_bit;
        w_sel_n       = r_sel;
        w_shift_n     = r_shift;
        w_prog_lat_n  = r_prog_lat;
        w_midi_n      = r_midi;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        w_pend_n      = r_pend;
        w_pend_slot_n = r_pend_slot;

        if (r_state != c_idle) begin
            w_baud_n = w_wrap ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            c_idle: begin
                // Every recall passes through the pending register, so an
                // idle recall and a queued one launch through the same path.
                if (r_pend) begin
                    w_state_n    = c_start;
                    w_baud_n     = '0;
                    w_bit_n      = 3'd0;
                    w_sel_n      = 1'b0;
                    w_shift_n    = c_status;
                    w_prog_lat_n = r_pend_slot ? r_prog2 : r_prog1;
                    w_midi_n     = 1'b0;
                    w_busy_n     = 1'b1;
                    w_pend_n     = 1'b0;
                end
            end
            c_start: begin
                if (w_wrap) begin
                    w_state_n = c_data;
                    w_midi_n  = r_shift[0];
                end
            end
            c_data: begin
                if (w_wrap) begin
                    if (r_bit == 3'd7) begin
                        w_state_n = c_stop;
                        w_bit_n   = 3'd0;
                        w_midi_n  = 1'b1;
                    end else begin
                        w_shift_n = r_shift >> 1;
                        w_midi_n  = r_shift[1];
                        w_bit_n   = r_bit + 3'd1;
                    end
                end
            end
            default: begin  // c_stop
                if (w_wrap) begin
                    if (!r_sel) begin
                        w_state_n = c_start;
                        w_sel_n   = 1'b1;
                        w_shift_n = {1'b0, r_prog_lat};
                        w_midi_n  = 1'b0;
                    end else begin
                        w_state_n = c_idle;
                        w_done_n  = 1'b1;
                        w_busy_n  = 1'b0;
                    end
                end
            end
        endcase

        // A recall in the launch cycle must survive the pending clear above.
        if (w_recall) begin
            w_pend_n      = 1'b1;
            w_pend_slot_n = btn_index[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_baud      <= '0;
            r_bit       <= 3'd0;
            r_sel       <= 1'b0;
            r_shift     <= 8'd0;
            r_prog_lat  <= 7'd0;
            r_midi      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_slot <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_baud      <= w_baud_n;
            r_bit       <= w_bit_n;
            r_sel       <= w_sel_n;
            r_shift     <= w_shift_n;
            r_prog_lat  <= w_prog_lat_n;
            r_midi      <= w_midi_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_pend      <= w_pend_n;
            r_pend_slot <= w_pend_slot_n;
        end
    end

    assign midi_out = r_midi;
    assign busy     = r_busy;
    assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_preset_midi_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_preset_midi_tx                                          |
// | Description : Self-checking bench for preset_midi_tx (CLK_DIV=4,         |
// |               CHANNEL=3). A vector table of button events with expected  |
// |               frames, plus sequences for queued recalls, save-in-flight  |
// |               and reset mid-frame.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_preset_midi_tx;

    localparam int         c_div    = 4;
    localparam logic [7:0] c_status = 8'hC3;

    logic       clk;
    logic       rst;
    logic [1:0] btn_index;
    logic       save_mode;
    logic [6:0] learn_program;
    logic       midi_out;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    preset_midi_tx #(
        .CLK_DIV   (c_div),
        .CHANNEL   (4'd3),
        .PROG1_INIT(7'd0),
        .PROG2_INIT(7'd1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_index    (btn_index),
        .save_mode    (save_mode),
        .learn_program(learn_program),
        .midi_out     (midi_out),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] btn;
        logic       save;
        logic [6:0] prog;
        logic       exp_frame;
        logic [7:0] exp_b1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // One-cycle event; sampled at the posedge between the two negedges.
    task automatic pulse(input logic [1:0] idx, input logic sv, input logic [6:0] p);
        @(negedge clk);
        btn_index     = idx;
        save_mode     = sv;
        learn_program = p;
        @(negedge clk);
        btn_index     = 2'd0;
        save_mode     = 1'b0;
        learn_program = 7'd0;
    endtask

    // Entered at the negedge right after the launch edge; leaves at the
    // negedge right after the tx_done edge.
    task automatic check_frame(input logic [7:0] b1, input string name);
        logic [19:0] exp_bits;
        logic [19:0] got_bits;
        exp_bits = {1'b1, b1, 1'b0, 1'b1, c_status, 1'b0};
        got_bits = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            got_bits[k] = midi_out;
            if (k < 19) repeat (c_div) @(negedge clk);
        end
        chk({name, "_frame"}, {12'd0, got_bits}, {12'd0, exp_bits});
        @(negedge clk);
        chk({name, "_pre_done"}, {30'd0, busy, tx_done}, {30'd0, 2'b10});
        @(negedge clk);
        chk({name, "_done"}, {29'd0, busy, tx_done, midi_out}, {29'd0, 3'b011});
    endtask

    // Checks the one-cycle launch latency, then the whole frame.
    task automatic launch_and_check(input logic [7:0] b1, input string name);
        chk({name, "_lat_pre"}, {30'd0, busy, midi_out}, {30'd0, 2'b01});
        @(negedge clk);
        chk({name, "_lat_post"}, {30'd0, busy, midi_out}, {30'd0, 2'b10});
        check_frame(b1, name);
    endtask

    task automatic do_recall(input logic [1:0] slot, input logic [7:0] b1, input string name);
        pulse(slot, 1'b0, 7'd0);
        launch_and_check(b1, name);
        @(negedge clk);
        chk({name, "_done_width"}, {31'd0, tx_done}, 32'd0);
    endtask

    task automatic check_quiet(input string name);
        logic bad;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || midi_out !== 1'b1 || tx_done !== 1'b0) bad = 1'b1;
        end
        chk({name, "_quiet"}, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        btn_index     = 2'd0;
        save_mode     = 1'b0;
        learn_program = 7'd0;
        rst           = 1'b1;

        vecs[0] = '{2'd1, 1'b0, 7'h00, 1'b1, 8'h00};  // recall slot 1 (init 0)
        vecs[1] = '{2'd2, 1'b1, 7'h45, 1'b0, 8'h00};  // save slot 2 = 0x45
        vecs[2] = '{2'd2, 1'b0, 7'h00, 1'b1, 8'h45};  // recall slot 2
        vecs[3] = '{2'd3, 1'b1, 7'h11, 1'b0, 8'h00};  // idx 3 save: ignored
        vecs[4] = '{2'd3, 1'b0, 7'h00, 1'b0, 8'h00};  // idx 3 recall: ignored
        vecs[5] = '{2'd1, 1'b0, 7'h00, 1'b1, 8'h00};  // slot 1 unchanged
        vecs[6] = '{2'd2, 1'b0, 7'h00, 1'b1, 8'h45};  // slot 2 unchanged
        vecs[7] = '{2'd0, 1'b1, 7'h22, 1'b0, 8'h00};  // idx 0 save: ignored
        vecs[8] = '{2'd1, 1'b0, 7'h00, 1'b1, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, midi_out, busy, tx_done}, {29'd0, 3'b100});
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].btn, vecs[i].save, vecs[i].prog);
            if (vecs[i].exp_frame) begin
                launch_and_check(vecs[i].exp_b1, $sformatf("vec%0d", i));
                @(negedge clk);
                chk($sformatf("vec%0d_done_width", i), {31'd0, tx_done}, 32'd0);
            end else begin
                check_quiet($sformatf("vec%0d", i));
            end
        end

        // Two recalls while busy: only the later one (slot 1) is sent, and it
        // launches one cycle after the first tx_done.
        pulse(2'd1, 1'b0, 7'd0);
        @(negedge clk);
        fork
            check_frame(8'h00, "b2b_first");
            begin
                repeat (10) @(negedge clk);
                pulse(2'd2, 1'b0, 7'd0);
                repeat (10) @(negedge clk);
                pulse(2'd1, 1'b0, 7'd0);
            end
        join
        @(negedge clk);
        chk("b2b_launch", {29'd0, tx_done, busy, midi_out}, {29'd0, 3'b010});
        check_frame(8'h00, "b2b_second");
        check_quiet("b2b_no_third");

        // Save to the slot in flight during byte 0: byte 1 keeps the old value.
        pulse(2'd2, 1'b0, 7'd0);
        @(negedge clk);
        fork
            check_frame(8'h45, "inflight");
            begin
                repeat (8) @(negedge clk);
                pulse(2'd2, 1'b1, 7'h7F);
            end
        join
        do_recall(2'd2, 8'h7F, "after_save");

        // Reset while a zero data bit (bit 2 of 0xC3) is on the line.
        pulse(2'd1, 1'b0, 7'd0);
        @(negedge clk);
        repeat (13) @(negedge clk);
        chk("mid_data_low", {30'd0, busy, midi_out}, {30'd0, 2'b10});
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {29'd0, midi_out, busy, tx_done}, {29'd0, 3'b100});
        @(negedge clk);
        rst = 1'b0;
        do_recall(2'd2, 8'h01, "rst_slot2_init");
        do_recall(2'd1, 8'h00, "rst_slot1_init");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
